// File: rtl/ls323_seq.sv
`timescale 1ns/1ps
// ls323_seq -- command sequencer for one 8-bit LS323-type universal shift register.
//
// Turns byte-level commands into the register's S1/S0, G1/G2 and CLR controls and
// drives the shared 8-bit I/O bus during parallel loads. The register runs on the
// same clk, so every control is decoded from the current state and is stable for
// the whole cycle before the edge that uses it.
//
// Optional feature: define LS323_SEQ_TURN_EN to insert one TURN cycle whenever a
// command starts driving the bus from the side opposite to its last driver.
//
// Parameters
//   SETTLE     register output-enable cycles before rd_data capture (1..7)
// Ports
//   clk        system clock, shared with the shift register
//   clr        asynchronous active-low reset of this controller
//   cmd_valid  command request
//   cmd_ready  idle; a command is accepted on posedge clk when valid & ready
//   cmd_op     00 CLEAR, 01 TX (load+shift), 10 RX (shift+read), 11 SHIFT
//   cmd_dir    0 right shift (S=01), 1 left shift (S=10)
//   cmd_len    shift count, 9..15 saturate to 8
//   cmd_data   parallel byte for TX
//   sr_s1/s0   register mode select
//   sr_g1/g2   register output enables, active low
//   sr_clr     register synchronous clear, active low
//   bus_out    controller drive value for the shared bus
//   bus_oe     controller drives bus_out onto the bus
//   bus_in     sampled value of the shared bus
//   rd_data    byte captured by the last RX
//   done       one-cycle completion pulse
module ls323_seq #(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic       cmd_dir,
   input  logic [3:0] cmd_len,
   input  logic [7:0] cmd_data,
   output logic       sr_s1,
   output logic       sr_s0,
   output logic       sr_g1,
   output logic       sr_g2,
   output logic       sr_clr,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   input  logic [7:0] bus_in,
   output logic [7:0] rd_data,
   output logic       done
);
   localparam logic [1:0] OP_CLEAR = 2'b00;
   localparam logic [1:0] OP_TX    = 2'b01;
   localparam logic [1:0] OP_RX    = 2'b10;
   localparam logic [1:0] OP_SHIFT = 2'b11;

   // READ runs SETTLE+1 output-enabled cycles plus one release cycle with the
   // register outputs off again, so nothing can be driven onto the bus while
   // the register is still turning its drivers off.
   localparam logic [3:0] RD_CYC = 4'(SETTLE + 2);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_LOAD, S_SHIFT, S_READ, S_DONE
`ifdef LS323_SEQ_TURN_EN
      , S_TURN
`endif
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [1:0] op_q;
   logic       dir_q;
   logic [3:0] len_q;
   logic [7:0] data_q;
   logic       accept;
   logic [3:0] len_c;

   assign len_c = (cmd_len > 4'd8) ? 4'd8 : cmd_len;

   // First working state of a command (after any bus turnaround).
   function automatic state_t first_st(input logic [1:0] op, input logic [3:0] len);
      case (op)
         OP_CLEAR: first_st = S_CLR;
         OP_TX:    first_st = S_LOAD;
         OP_RX:    first_st = (len == 4'd0) ? S_READ : S_SHIFT;
         default:  first_st = (len == 4'd0) ? S_DONE : S_SHIFT;
      endcase
   endfunction

   function automatic logic [3:0] first_cnt(input logic [1:0] op, input logic [3:0] len);
      first_cnt = (op == OP_RX && len == 4'd0) ? RD_CYC : len;
   endfunction

`ifdef LS323_SEQ_TURN_EN
   typedef enum logic [1:0] {DRV_NONE, DRV_CTRL, DRV_REG} drv_t;
   drv_t last_drv;
   logic need_turn;

   // Only commands whose first cycle puts a driver on the bus can collide.
   assign need_turn = (cmd_op == OP_TX && last_drv == DRV_REG) ||
                      (cmd_op == OP_RX && len_c == 4'd0 && last_drv == DRV_CTRL);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr)                 last_drv <= DRV_NONE;
      else if (state == S_LOAD) last_drv <= DRV_CTRL;
      else if (state == S_READ) last_drv <= DRV_REG;
   end
`endif

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         op_q    <= 2'b00;
         dir_q   <= 1'b0;
         len_q   <= 4'd0;
         data_q  <= 8'h00;
         rd_data <= 8'h00;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            op_q   <= cmd_op;
            dir_q  <= cmd_dir;
            len_q  <= len_c;
            data_q <= cmd_data;
         end
         if (state == S_READ && cnt == 4'd2) rd_data <= bus_in;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      cmd_ready = 1'b0;
      sr_s1     = 1'b0;
      sr_s0     = 1'b0;
      sr_g1     = 1'b1;
      sr_g2     = 1'b1;
      sr_clr    = 1'b1;
      bus_out   = 8'h00;
      bus_oe    = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept    = 1'b1;
               state_nxt = first_st(cmd_op, len_c);
               cnt_nxt   = first_cnt(cmd_op, len_c);
`ifdef LS323_SEQ_TURN_EN
               if (need_turn) state_nxt = S_TURN;
`endif
            end
         end
`ifdef LS323_SEQ_TURN_EN
         S_TURN: begin
            state_nxt = first_st(op_q, len_q);
            cnt_nxt   = first_cnt(op_q, len_q);
         end
`endif
         S_CLR: begin
            sr_clr    = 1'b0;
            state_nxt = S_DONE;
         end
         S_LOAD: begin
            sr_s1   = 1'b1;
            sr_s0   = 1'b1;
            bus_oe  = 1'b1;
            bus_out = data_q;
            if (len_q != 4'd0) begin
               state_nxt = S_SHIFT;
               cnt_nxt   = len_q;
            end else begin
               state_nxt = S_DONE;
            end
         end
         S_SHIFT: begin
            sr_s1   = dir_q;
            sr_s0   = ~dir_q;
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) begin
               if (op_q == OP_RX) begin
                  state_nxt = S_READ;
                  cnt_nxt   = RD_CYC;
               end else begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_READ: begin
            // Outputs enabled for all but the final (release) cycle.
            sr_g1   = (cnt <= 4'd1);
            sr_g2   = (cnt <= 4'd1);
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
